per_mem_ctrl: RTL and testbench
===============================

// Module: per_mem_ctrl
// PURPOSE
//  Parametrised word-organised memory peripheral for the XSimBus. Supports byte-enable
//  writes, a 1-cycle registered read, request/ack handshake, address range checking,
//  a sticky write-lock, and a zero-fill sequence after reset. Sits on the bus as a
//  selected device; serves as program ROM (locked after load) or data RAM.
// PARAMETERS
//  DATA_W      32  word width in bits; multiple of 8
//  ADDR_W      10  byte-address width presented by the bus
//  DEPTH_LOG2  6   log2 of word count (64 words by default); DEPTH_LOG2+2 <= ADDR_W
//  CLEAR_EN    1   1: zero-fill all words after reset; 0: skip fill, contents undefined
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, synchronous, active-high
//  sel_in     in   1          device selected by bus decoder
//  req_in     in   1          request strobe, valid with sel_in
//  rw_in      in   1          1 = read, 0 = write
//  addr_in    in   ADDR_W     byte address; bits [1:0] ignored
//  wdata_in   in   DATA_W     write data
//  be_in      in   DATA_W/8   byte-lane write enables; bit i -> wdata_in[8i+7:8i]
//  lock_in    in   1          pulse high: set sticky write-lock
//  ready_out  out  1          block can accept a request this cycle
//  ack_out    out  1          one-cycle pulse: response for request accepted last cycle
//  rdata_out  out  DATA_W     read data; valid only with ack_out on a read, else 0
//  err_out    out  1          with ack_out: request rejected (range or lock)
//  locked_out out  1          write-lock state
// BEHAVIOUR
//  - Reset: ready_out=0, ack_out=0, rdata_out=0, err_out=0, locked_out=0. FSM -> CLEAR
//    if CLEAR_EN=1, else RUN. Reset asserted mid-operation discards any pending ack
//    and restarts the fill from word 0.
//  - FSM CLEAR: counter walks 0..2^DEPTH_LOG2-1, writing one zero word per cycle;
//    ready_out=0; requests are ignored (no ack). After the last word -> RUN on the
//    next cycle. CLEAR lasts exactly 2^DEPTH_LOG2 cycles.
//  - FSM RUN: ready_out=1 every cycle; requests may be accepted back-to-back.
//  - Accept = sel_in & req_in & ready_out at a rising edge. Each accept yields exactly
//    one ack_out pulse on the following cycle. No accept -> ack_out=0.
//  - Word index = addr_in[DEPTH_LOG2+1:2]. Out of range if addr_in[ADDR_W-1:DEPTH_LOG2+2]
//    is nonzero: ack with err_out=1, rdata_out=0, no memory change.
//  - Read: rdata_out = word contents at accept time, registered, presented with ack.
//  - Write: each lane with be_in[i]=1 is updated at the accept edge; other lanes kept.
//    be_in=0 is a legal no-op write and is acked with err_out=0.
//  - Read accepted the cycle after a write to the same word returns the new data.
//  - Lock: lock_in=1 sets locked_out at the next edge; it is cleared only by rst.
//    Writes while locked are acked with err_out=1 and no change. Reads are unaffected.
//    A write accepted on the same edge that lock_in is sampled still completes.
//  - Out-of-range and locked together: a single err ack.
//  - rdata_out and err_out are 0 in every cycle where ack_out=0.
// TESTING
//  1. Reset with CLEAR_EN=1: ready_out=0 for exactly 64 cycles, then 1; read any word
//     -> ack next cycle, rdata_out=0, err_out=0.
//  2. Write 0xAABBCCDD, be=4'hF, addr 0x010; then write 0x00001100, be=4'b0010, same
//     address; then read -> 0xAABB11DD.
//  3. Back-to-back: write addr 0x004 = 0x12345678, read 0x004 next cycle -> 0x12345678;
//     three consecutive reads -> three consecutive ack pulses.
//  4. Access addr 0x100 (range 0x000-0x0FF) -> ack with err_out=1; read and write
//     both give err; a later read of 0x000 is unchanged.
//  5. Pulse lock_in; write 0xDEADBEEF to 0x008 -> err_out=1; read 0x008 returns the
//     old value with err_out=0; locked_out stays 1 until rst.
//  6. Assert rst at fill cycle 30 for 1 cycle -> outputs reset, fill restarts, and
//     ready_out rises 64 cycles after rst is released.

Source files
------------

// File: rtl/per_mem_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : per_mem_ctrl
// Brief    : XSimBus word memory with byte enables, registered read, range
//            check, sticky write-lock and post-reset zero fill.
// Revision : 1.0
//------------------------------------------------------------------------------
module per_mem_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int DEPTH_LOG2 = 6,
  parameter bit CLEAR_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_in,
  input  logic                req_in,
  input  logic                rw_in,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   wdata_in,
  input  logic [DATA_W/8-1:0] be_in,
  input  logic                lock_in,
  output logic                ready_out,
  output logic                ack_out,
  output logic [DATA_W-1:0]   rdata_out,
  output logic                err_out,
  output logic                locked_out
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  locked_q;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  accept;
  logic                  oor;
  logic                  wr_en;
  logic                  clr_we;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr_in[1:0];
  assign idx              = addr_in[DEPTH_LOG2+1:2];

  generate
    if (DEPTH_LOG2 + 2 < ADDR_W) begin : g_range_chk
      assign oor = |addr_in[ADDR_W-1:DEPTH_LOG2+2];
    end else begin : g_no_range_chk
      assign oor = 1'b0;
    end
  endgenerate

  // rst gates ready so nothing is accepted on a reset edge
  assign ready_out = (state_q == S_RUN) && !rst;
  assign accept    = sel_in && req_in && ready_out;
  assign wr_en     = accept && !rw_in && !oor && !locked_q;
  assign clr_we    = (state_q == S_CLEAR) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_EN ? S_CLEAR : S_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == {DEPTH_LOG2{1'b1}}) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      ack_q    <= accept;
      err_q    <= accept && (oor || (!rw_in && locked_q));
      rdata_q  <= (accept && rw_in && !oor) ? mem_q[idx] : '0;
      locked_q <= locked_q || lock_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be_in[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_in[8*i +: 8];
        end
      end
    end
  end

  assign ack_out    = ack_q;
  assign err_out    = err_q;
  assign rdata_out  = rdata_q;
  assign locked_out = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_per_mem_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_per_mem_ctrl
// Brief    : Scoreboard bench for per_mem_ctrl with directed vectors.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_per_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_in, req_in, rw_in, lock_in;
  logic [9:0]  addr_in;
  logic [31:0] wdata_in;
  logic [3:0]  be_in;
  logic        ready_out, ack_out, err_out, locked_out;
  logic [31:0] rdata_out;

  int tests = 0;
  int fails = 0;
  logic [31:0] cyc = '0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;
  exp_t sb_q[$];

  per_mem_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH_LOG2(6), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .sel_in(sel_in), .req_in(req_in), .rw_in(rw_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .be_in(be_in), .lock_in(lock_in),
    .ready_out(ready_out), .ack_out(ack_out), .rdata_out(rdata_out),
    .err_out(err_out), .locked_out(locked_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected ack is one cycle after the accepting edge
  always @(negedge clk) begin
    exp_t e;
    if (ack_out) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_latency", cyc, e.cyc);
        chk("rdata", rdata_out, e.rdata);
        chk("err", {31'd0, err_out}, {31'd0, e.err});
      end
    end else begin
      chk("idle_zero", {rdata_out[30:0], err_out}, 32'd0);
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        chk("missing_ack", 32'd0, 32'd1);
      end
    end
  end

  // Called at a negedge; returns at the next negedge with the request still driven
  task automatic issue(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    sel_in = 1'b1; req_in = 1'b1; rw_in = rw; addr_in = a; wdata_in = wd; be_in = be;
    e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    sel_in = 1'b0; req_in = 1'b0; rw_in = 1'b0; be_in = '0; lock_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic count_fill(input string name);
    int n = 0;
    #1;
    while (!ready_out && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 32'd64);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel_in = 0; req_in = 0; rw_in = 0; lock_in = 0;
    addr_in = '0; wdata_in = '0; be_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  {31'd0, ready_out},  32'd0);
    chk("rst_ack",    {31'd0, ack_out},    32'd0);
    chk("rst_rdata",  rdata_out,           32'd0);
    chk("rst_err",    {31'd0, err_out},    32'd0);
    chk("rst_locked", {31'd0, locked_out}, 32'd0);

    // 1: zero fill
    rst = 1'b0;
    count_fill("fill_len");
    issue(1'b1, 10'h014, '0, 4'h0, 32'h0, 1'b0);
    issue(1'b1, 10'h0FC, '0, 4'h0, 32'h0, 1'b0);
    idle(2);

    // 2: byte-enable merge
    issue(1'b0, 10'h010, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 10'h010, 32'h00001100, 4'b0010, 32'h0, 1'b0);
    issue(1'b1, 10'h010, '0, 4'h0, 32'hAABB11DD, 1'b0);
    idle(2);

    // 3: back-to-back, read-after-write, be=0 no-op
    issue(1'b0, 10'h004, 32'h12345678, 4'hF, 32'h0, 1'b0);
    issue(1'b1, 10'h004, '0, 4'h0, 32'h12345678, 1'b0);
    issue(1'b1, 10'h013, '0, 4'h0, 32'hAABB11DD, 1'b0);
    issue(1'b1, 10'h000, '0, 4'h0, 32'h0, 1'b0);
    issue(1'b1, 10'h006, '0, 4'h0, 32'h12345678, 1'b0);
    issue(1'b0, 10'h004, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    issue(1'b1, 10'h004, '0, 4'h0, 32'h12345678, 1'b0);
    idle(2);

    // 4: out-of-range (0x100 aliases word 0 if unchecked)
    issue(1'b1, 10'h100, '0, 4'h0, 32'h0, 1'b1);
    issue(1'b0, 10'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    issue(1'b0, 10'h3FC, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    issue(1'b1, 10'h000, '0, 4'h0, 32'h0, 1'b0);
    issue(1'b1, 10'h0FC, '0, 4'h0, 32'h0, 1'b0);
    idle(2);

    // 5: lock; write on the locking edge still completes
    lock_in = 1'b1;
    issue(1'b0, 10'h008, 32'h11111111, 4'hF, 32'h0, 1'b0);
    lock_in = 1'b0;
    chk("locked_set", {31'd0, locked_out}, 32'd1);
    issue(1'b0, 10'h008, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1);
    issue(1'b1, 10'h008, '0, 4'h0, 32'h11111111, 1'b0);
    issue(1'b0, 10'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1);
    issue(1'b0, 10'h010, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1'b1, 10'h010, '0, 4'h0, 32'hAABB11DD, 1'b0);
    idle(5);
    chk("locked_sticky", {31'd0, locked_out}, 32'd1);

    // 6: reset with a request pending is not accepted; reset mid-fill restarts
    rst = 1'b1; sel_in = 1'b1; req_in = 1'b1; rw_in = 1'b1; addr_in = 10'h010;
    @(negedge clk);
    idle(0);
    chk("rst2_locked", {31'd0, locked_out}, 32'd0);
    chk("rst2_ready",  {31'd0, ready_out},  32'd0);
    rst = 1'b0;
    idle(30);
    chk("fill_busy", {31'd0, ready_out}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst3_ready", {31'd0, ready_out}, 32'd0);
    chk("rst3_ack",   {31'd0, ack_out},   32'd0);
    rst = 1'b0;
    count_fill("refill_len");
    issue(1'b1, 10'h010, '0, 4'h0, 32'h0, 1'b0);
    issue(1'b0, 10'h008, 32'h0000ABCD, 4'hF, 32'h0, 1'b0);
    issue(1'b1, 10'h008, '0, 4'h0, 32'h0000ABCD, 1'b0);
    idle(4);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
